controller_fsm_ms: RTL
======================

Name: controller_fsm_ms

Overview:
- Multi-state, parametrised instruction controller for the accumulator SoC datapath.
- Replaces the two-phase toggling controller with explicit RESET/FETCH/EXEC/HALT states.
- Adds a memory-ready fetch handshake, inverted-flag branches, a resumable halt, and a configurable illegal-opcode policy.
- Drives ALU select, accumulator mux/load, register load, PC mux/load/increment, and IR load.

Parameters:
- OPW, 4: opcode width; SelALU width equals OPW; must be >= 4.
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode enters S_HALT with Illegal=1; 0 = illegal opcode executes as NOP with Illegal pulsed for one cycle.
- FETCH_TIMEOUT, 0: 0 = wait forever for MemRdy; N>0 = after N FETCH cycles without MemRdy, enter S_HALT with Timeout=1.

Ports:
- CLK  in  1  clock, rising edge.
- CLB  in  1  reset, asynchronous, active-high.
- Opcode  in  OPW  current IR opcode; valid in S_EXEC.
- Z  in  1  zero flag.
- C  in  1  carry flag.
- MemRdy  in  1  instruction memory data valid.
- Resume  in  1  leave S_HALT; level, sampled at clock edge.
- SelALU  out  OPW  ALU operation select.
- SelAcc  out  2  accumulator source: 01 ALU, 10 Reg, 00 immediate.
- LoadAcc, LoadReg, LoadPC, SelPC, IncPC, LoadIR  out  1 each  datapath strobes; SelPC 0 = register, 1 = immediate.
- FetchReq  out  1  instruction read request.
- Halted, Illegal, Timeout  out  1 each  status.

Behaviour:
- State register resets asynchronously to S_RESET.
- All outputs are combinational from state, Opcode, Z, C, MemRdy, plus sticky status flags.
- S_RESET: all outputs 0. Next edge goes to S_FETCH unconditionally.
- S_FETCH: FetchReq=1 and LoadIR=MemRdy; all other strobes 0.
  - If MemRdy, next state is S_EXEC.
  - Timeout counter (clog2(FETCH_TIMEOUT+1) bits) clears on entry to S_FETCH and increments each cycle without MemRdy.
  - When the counter reaches FETCH_TIMEOUT-1 with no MemRdy, next state is S_HALT and sticky Timeout is set.
- S_EXEC: exactly one cycle, then S_FETCH unless halting. Default IncPC=1; any strobe not listed below is 0.
  - ADD 0001, SUB 0010, NOR 0011, SHL 1011, SHR 1100: SelALU=Opcode, SelAcc=01, LoadAcc=1.
  - LDRA 0100 (Reg->Acc): SelAcc=10, LoadAcc=1.
  - LDAR 0101 (Acc->Reg): LoadReg=1.
  - LDI 1101 (Imm->Acc): SelAcc=00, LoadAcc=1.
  - BZR 0110 (Z, reg target), BZI 0111 (Z, imm), BCR 1000 (C, reg), BCI 1010 (C, imm), BNZI 1001 (!Z, imm), BNCI 1110 (!C, imm).
  - Branch taken: LoadPC=1, SelPC per target, IncPC=0. Branch not taken: IncPC=1 only.
  - NOP 0000: IncPC=1 only.
  - HALT 1111: IncPC=0, next state S_HALT.
  - Any code with bits above [3:0] nonzero is illegal: IncPC=1, Illegal=1. If HALT_ON_ILLEGAL, IncPC=0, next state S_HALT, Illegal stays sticky.
  - SelALU=0 and SelAcc=00 whenever LoadAcc=0.
- S_HALT: all strobes 0, Halted=1.
  - Resume=1 at an edge goes to S_FETCH and clears sticky Illegal and Timeout.
  - Resume in any other state is ignored.
- Exactly one of LoadPC/IncPC may be 1 in any cycle; never both.
- Reset mid-operation: immediate return to S_RESET, all outputs 0, counter and status cleared.
- Instruction latency: minimum 2 cycles (FETCH with MemRdy=1, then EXEC).

Decomposition:
- Package controller_pkg:
  - opcode localparams (OP_NOP ... OP_HALT, OP_BNZI, OP_BNCI);
  - SelAcc encodings ACC_IMM/ACC_ALU/ACC_REG;
  - state enum {S_RESET, S_FETCH, S_EXEC, S_HALT}.
- One sub-module, ctrl_decode: purely combinational opcode+flags -> strobe bundle and halt/illegal indications. The FSM wraps it and gates it with state == S_EXEC.

Test Plan:
- CLB=1 for 2 cycles, then release with MemRdy=1, Opcode=0001 -> cycle 1 S_FETCH: FetchReq=1, LoadIR=1; cycle 2: SelALU=0001, SelAcc=01, LoadAcc=1, IncPC=1.
- MemRdy=0 for 3 cycles then 1, FETCH_TIMEOUT=0 -> LoadIR=0 ×3, then LoadIR=1; no other strobe during the wait.
- Opcode=1001 with Z=0 -> LoadPC=1, SelPC=1, IncPC=0. Same opcode with Z=1 -> IncPC=1, LoadPC=0.
- Opcode=1111 -> next cycle Halted=1 and all strobes 0 for 5 cycles; Resume=1 -> S_FETCH with FetchReq=1.
- OPW=5, Opcode=10001 -> with HALT_ON_ILLEGAL=1: Illegal=1, Halted=1. With HALT_ON_ILLEGAL=0: IncPC=1 and one-cycle Illegal pulse.
- FETCH_TIMEOUT=4, MemRdy held 0 -> Timeout=1, Halted=1 after 4 FETCH cycles. Assert CLB while in S_EXEC -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared opcode map, accumulator/PC source encodings and FSM state type
// for the multi-state instruction controller.
package controller_pkg;

  // 4-bit opcode map; wider opcodes are legal only when the upper bits are zero
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_LDRA = 4'b0100;
  localparam logic [3:0] OP_LDAR = 4'b0101;
  localparam logic [3:0] OP_BZR  = 4'b0110;
  localparam logic [3:0] OP_BZI  = 4'b0111;
  localparam logic [3:0] OP_BCR  = 4'b1000;
  localparam logic [3:0] OP_BNZI = 4'b1001;
  localparam logic [3:0] OP_BCI  = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_LDI  = 4'b1101;
  localparam logic [3:0] OP_BNCI = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Accumulator source select
  localparam logic [1:0] ACC_IMM = 2'b00;
  localparam logic [1:0] ACC_ALU = 2'b01;
  localparam logic [1:0] ACC_REG = 2'b10;

  // PC source select
  localparam logic PC_REG = 1'b0;
  localparam logic PC_IMM = 1'b1;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  // Datapath strobes produced by the decoder for one EXEC cycle
  typedef struct packed {
    logic [1:0] sel_acc;
    logic       load_acc;
    logic       load_reg;
    logic       load_pc;
    logic       sel_pc;
    logic       inc_pc;
  } strobes_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/flag decoder: produces the EXEC-cycle strobe bundle
// plus halt and illegal indications. The FSM gates all of it with S_EXEC.
module ctrl_decode
  import controller_pkg::*;
#(
  parameter int unsigned OPW             = 4,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic [OPW-1:0] opcode_i,
  input  logic           z_i,
  input  logic           c_i,
  output logic [OPW-1:0] sel_alu_o,
  output strobes_t       strb_o,
  output logic           halt_o,
  output logic           illegal_o
);

  logic [OPW-1:0] upper;
  logic [3:0]     op;
  logic           is_br;
  logic           br_cond;
  logic           br_tgt;

  // Shift rather than slice so OPW == 4 needs no special case
  assign upper = opcode_i >> 4;
  assign op    = opcode_i[3:0];

  // Decode opcode into strobes; branches resolved after the case
  always_comb begin
    sel_alu_o      = '0;
    strb_o         = '0;
    strb_o.inc_pc  = 1'b1;
    halt_o         = 1'b0;
    illegal_o      = 1'b0;
    is_br          = 1'b0;
    br_cond        = 1'b0;
    br_tgt         = PC_REG;

    if (|upper) begin
      illegal_o = 1'b1;
      if (HALT_ON_ILLEGAL) begin
        strb_o.inc_pc = 1'b0;
        halt_o        = 1'b1;
      end
    end else begin
      case (op)
        OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
          sel_alu_o       = opcode_i;
          strb_o.sel_acc  = ACC_ALU;
          strb_o.load_acc = 1'b1;
        end
        OP_LDRA: begin
          strb_o.sel_acc  = ACC_REG;
          strb_o.load_acc = 1'b1;
        end
        OP_LDAR: strb_o.load_reg = 1'b1;
        OP_LDI: begin
          strb_o.sel_acc  = ACC_IMM;
          strb_o.load_acc = 1'b1;
        end
        OP_BZR: begin
          is_br = 1'b1; br_cond = z_i;  br_tgt = PC_REG;
        end
        OP_BZI: begin
          is_br = 1'b1; br_cond = z_i;  br_tgt = PC_IMM;
        end
        OP_BCR: begin
          is_br = 1'b1; br_cond = c_i;  br_tgt = PC_REG;
        end
        OP_BCI: begin
          is_br = 1'b1; br_cond = c_i;  br_tgt = PC_IMM;
        end
        OP_BNZI: begin
          is_br = 1'b1; br_cond = !z_i; br_tgt = PC_IMM;
        end
        OP_BNCI: begin
          is_br = 1'b1; br_cond = !c_i; br_tgt = PC_IMM;
        end
        OP_HALT: begin
          strb_o.inc_pc = 1'b0;
          halt_o        = 1'b1;
        end
        default: ; // OP_NOP: increment only
      endcase

      // Taken branch swaps increment for a PC load; the two are exclusive
      if (is_br && br_cond) begin
        strb_o.load_pc = 1'b1;
        strb_o.sel_pc  = br_tgt;
        strb_o.inc_pc  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/controller_fsm_ms.sv
// Multi-state instruction controller: RESET -> FETCH (waits on MemRdy,
// optional timeout) -> EXEC (one cycle) -> FETCH, with a resumable HALT.
module controller_fsm_ms
  import controller_pkg::*;
#(
  parameter int unsigned OPW             = 4,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned FETCH_TIMEOUT   = 0
) (
  input  logic           CLK,
  input  logic           CLB,
  input  logic [OPW-1:0] Opcode,
  input  logic           Z,
  input  logic           C,
  input  logic           MemRdy,
  input  logic           Resume,
  output logic [OPW-1:0] SelALU,
  output logic [1:0]     SelAcc,
  output logic           LoadAcc,
  output logic           LoadReg,
  output logic           LoadPC,
  output logic           SelPC,
  output logic           IncPC,
  output logic           LoadIR,
  output logic           FetchReq,
  output logic           Halted,
  output logic           Illegal,
  output logic           Timeout
);

  // Counter needs at least one bit even when the timeout is disabled
  localparam int unsigned CntW = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast =
      (FETCH_TIMEOUT > 0) ? CntW'(FETCH_TIMEOUT - 1) : '0;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;

  logic [OPW-1:0]  dec_sel_alu;
  strobes_t        dec_strb;
  logic            dec_halt;
  logic            dec_illegal;

  ctrl_decode #(
    .OPW             (OPW),
    .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
  ) u_decode (
    .opcode_i  (Opcode),
    .z_i       (Z),
    .c_i       (C),
    .sel_alu_o (dec_sel_alu),
    .strb_o    (dec_strb),
    .halt_o    (dec_halt),
    .illegal_o (dec_illegal)
  );

  // State, fetch-wait counter and sticky status registers
  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state; counter held at zero outside FETCH so it clears on entry
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (MemRdy) begin
          state_d = S_EXEC;
        end else if (FETCH_TIMEOUT != 0) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d   = S_HALT;
            timeout_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (dec_halt) begin
          state_d   = S_HALT;
          illegal_d = illegal_q | dec_illegal;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (Resume) begin
          state_d   = S_FETCH;
          illegal_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // Moore/Mealy outputs: decoder strobes only pass through in S_EXEC
  always_comb begin
    SelALU   = '0;
    SelAcc   = ACC_IMM;
    LoadAcc  = 1'b0;
    LoadReg  = 1'b0;
    LoadPC   = 1'b0;
    SelPC    = 1'b0;
    IncPC    = 1'b0;
    LoadIR   = 1'b0;
    FetchReq = 1'b0;
    Halted   = 1'b0;
    Illegal  = illegal_q;
    Timeout  = timeout_q;
    unique case (state_q)
      S_FETCH: begin
        FetchReq = 1'b1;
        LoadIR   = MemRdy;
      end
      S_EXEC: begin
        SelALU  = dec_sel_alu;
        SelAcc  = dec_strb.sel_acc;
        LoadAcc = dec_strb.load_acc;
        LoadReg = dec_strb.load_reg;
        LoadPC  = dec_strb.load_pc;
        SelPC   = dec_strb.sel_pc;
        IncPC   = dec_strb.inc_pc;
        Illegal = illegal_q | dec_illegal;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule
